// File: rtl/muldiv_ctrl.sv
// Multi-cycle 32x32 multiply / divide unit with HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle, sign correction in a final state.
module muldiv_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  fun_c,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        div0,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [5:0]  cnt_r;
    logic [63:0] prod_r;
    logic [31:0] opnd_r;
    logic        is_div_r;
    logic        neg_q_r;
    logic        neg_r_r;
    logic        zero_r;
    logic        busy_r;
    logic        done_r;
    logic        div0_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;

    logic        a_neg_s;
    logic        b_neg_s;
    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;
    logic [32:0] mul_sum_s;
    logic [63:0] mul_next_s;
    logic [32:0] div_sh_s;
    logic [33:0] div_diff_s;
    logic [63:0] div_next_s;
    logic [63:0] prod_neg_s;
    logic [31:0] res_hi_s;
    logic [31:0] res_lo_s;

    // Two's-complement magnitude of a value when it is treated as signed and negative.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
        logic [31:0] r;
        if (neg) begin
            r = 32'd0 - v;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Conditional 32-bit negation used for the final sign correction.
    function automatic logic [31:0] cneg32(input logic [31:0] v, input logic neg);
        logic [31:0] r;
        if (neg) begin
            r = 32'd0 - v;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Operand signs/magnitudes and the single-iteration datapath for both operations.
    always_comb begin
        a_neg_s    = fun_c[0] & a[31];
        b_neg_s    = fun_c[0] & b[31];
        a_mag_s    = mag32(a, a_neg_s);
        b_mag_s    = mag32(b, b_neg_s);
        // The carry of the partial-product add shifts down into bit 63.
        mul_sum_s  = {1'b0, prod_r[63:32]} + (prod_r[0] ? {1'b0, opnd_r} : 33'd0);
        mul_next_s = {mul_sum_s, prod_r[31:1]};
        div_sh_s   = {prod_r[63:32], prod_r[31]};
        div_diff_s = {1'b0, div_sh_s} - {2'b00, opnd_r};
        if (div_diff_s[33]) begin
            div_next_s = {div_sh_s[31:0], prod_r[30:0], 1'b0};
        end else begin
            div_next_s = {div_diff_s[31:0], prod_r[30:0], 1'b1};
        end
    end

    // Sign-corrected result presented while in SIGN.
    always_comb begin
        prod_neg_s = 64'd0 - prod_r;
        if (is_div_r) begin
            res_lo_s = cneg32(prod_r[31:0], neg_q_r);
            res_hi_s = cneg32(prod_r[63:32], neg_r_r);
        end else if (neg_q_r) begin
            res_lo_s = prod_neg_s[31:0];
            res_hi_s = prod_neg_s[63:32];
        end else begin
            res_lo_s = prod_r[31:0];
            res_hi_s = prod_r[63:32];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = CALC;
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == 6'd31) begin
                    state_s = SIGN;
                end else begin
                    state_s = CALC;
                end
            end
            SIGN:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Datapath, HI/LO and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r    <= 6'd0;
            prod_r   <= 64'd0;
            opnd_r   <= 32'd0;
            is_div_r <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            zero_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            div0_r   <= 1'b0;
            hi_r     <= 32'd0;
            lo_r     <= 32'd0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        // Start wins over a coincident mthi/mtlo.
                        cnt_r    <= 6'd0;
                        busy_r   <= 1'b1;
                        div0_r   <= 1'b0;
                        is_div_r <= fun_c[1];
                        neg_q_r  <= a_neg_s ^ b_neg_s;
                        neg_r_r  <= a_neg_s;
                        zero_r   <= (b == 32'd0);
                        if (fun_c[1]) begin
                            prod_r <= {32'd0, a_mag_s};
                            opnd_r <= b_mag_s;
                        end else begin
                            prod_r <= {32'd0, b_mag_s};
                            opnd_r <= a_mag_s;
                        end
                    end else begin
                        if (mthi) begin
                            hi_r <= wdata;
                        end else begin
                            hi_r <= hi_r;
                        end
                        if (mtlo) begin
                            lo_r <= wdata;
                        end else begin
                            lo_r <= lo_r;
                        end
                    end
                end
                CALC: begin
                    cnt_r <= cnt_r + 6'd1;
                    if (is_div_r) begin
                        prod_r <= div_next_s;
                    end else begin
                        prod_r <= mul_next_s;
                    end
                end
                SIGN: begin
                    cnt_r  <= 6'd0;
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                    div0_r <= is_div_r & zero_r;
                    if (!(is_div_r && zero_r)) begin
                        hi_r <= res_hi_s;
                        lo_r <= res_lo_s;
                    end else begin
                        hi_r <= hi_r;
                        lo_r <= lo_r;
                    end
                end
                default: begin
                    cnt_r  <= 6'd0;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign div0 = div0_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  fun_c;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div0;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_ctrl dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .fun_c (fun_c),
        .a     (a),
        .b     (b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .div0  (div0),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and wait (bounded) for done; checks latency and busy during done.
    task automatic run_op(input string tag, input logic [1:0] f, input logic [31:0] va, input logic [31:0] vb);
        int n;
        start = 1'b1;
        fun_c = f;
        a     = va;
        b     = vb;
        tick();
        start = 1'b0;
        a     = 32'h5a5a_5a5a;
        b     = 32'h0000_0003;
        fun_c = 2'b00;
        check_val({tag, "_busy"}, {63'd0, busy}, 64'd1);
        n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        check_val({tag, "_lat"}, n, 64'd33);
        check_val({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        int n_done;
        int first_done;
        rst   = 1'b1;
        start = 1'b0;
        fun_c = 2'b00;
        a     = 32'd0;
        b     = 32'd0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        wdata = 32'd0;
        tick();
        tick();
        rst = 1'b0;
        check_val("rst_busy", {63'd0, busy}, 64'd0);
        check_val("rst_done", {63'd0, done}, 64'd0);
        check_val("rst_div0", {63'd0, div0}, 64'd0);
        check_val("rst_hilo", {hi, lo}, 64'd0);

        run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check_val("multu_max_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

        run_op("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'd5);
        check_val("mult_neg_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);

        run_op("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2);
        check_val("div_neg_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        run_op("div_negdiv", 2'b11, 32'd7, 32'hFFFF_FFFE);
        check_val("div_negdiv_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFD);

        run_op("divu_big", 2'b10, 32'hFFFF_FFFF, 32'h0000_0010);
        check_val("divu_big_hilo", {hi, lo}, 64'h0000_000F_0FFF_FFFF);

        run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        check_val("div_ovf_hilo", {hi, lo}, 64'h0000_0000_8000_0000);
        check_val("div_ovf_div0", {63'd0, div0}, 64'd0);

        // mthi/mtlo then divide by zero must leave HI/LO alone.
        mthi  = 1'b1;
        wdata = 32'h0000_1234;
        tick();
        mthi  = 1'b0;
        mtlo  = 1'b1;
        wdata = 32'h0000_5678;
        tick();
        mtlo  = 1'b0;
        check_val("mt_hilo", {hi, lo}, 64'h0000_1234_0000_5678);
        run_op("divu_zero", 2'b10, 32'd7, 32'd0);
        check_val("divu_zero_div0", {63'd0, div0}, 64'd1);
        check_val("divu_zero_hilo", {hi, lo}, 64'h0000_1234_0000_5678);

        // Start + mthi while busy are both ignored.
        start = 1'b1;
        fun_c = 2'b00;
        a     = 32'd6;
        b     = 32'd7;
        tick();
        start = 1'b0;
        check_val("div0_clear", {63'd0, div0}, 64'd0);
        n_done     = 0;
        first_done = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 4) begin
                start = 1'b1;
                mthi  = 1'b1;
                fun_c = 2'b10;
                a     = 32'd100;
                wdata = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0;
                mthi  = 1'b0;
            end
            tick();
            if (done) begin
                n_done++;
                if (first_done == 0) first_done = k;
            end
        end
        check_val("ignore_ndone", n_done, 64'd1);
        check_val("ignore_lat", first_done, 64'd33);
        check_val("ignore_hilo", {hi, lo}, 64'd42);
        check_val("ignore_idle", {63'd0, busy}, 64'd0);

        // Reset in the middle of a multiply.
        start = 1'b1;
        fun_c = 2'b01;
        a     = 32'd3;
        b     = 32'd4;
        tick();
        start = 1'b0;
        for (int k = 1; k < 10; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("midrst_busy", {63'd0, busy}, 64'd0);
        check_val("midrst_hilo", {hi, lo}, 64'd0);
        n_done = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) n_done++;
            tick();
        end
        check_val("midrst_nodone", n_done, 64'd0);
        run_op("after_rst", 2'b00, 32'h0001_0000, 32'h0001_0000);
        check_val("after_rst_hilo", {hi, lo}, 64'h0000_0001_0000_0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
